// File: rtl/crc16_pkt_ctrl_pkg.sv
// Shared USB CRC16 definitions: packet-controller state encoding, size defaults
// and the serial CRC16 (x^16+x^15+x^2+1) constants and bit-step helper.
package crc16_pkt_ctrl_pkg;

  localparam int MAX_BYTES_DEF = 1024;
  localparam int CNT_W_DEF     = 11;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  // Remainder left in the register after a good packet plus its inverted CRC.
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD,
    DATA,
    CRC,
    CHECK,
    WAIT,
    DONE
  } pkt_state_e;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc_16.sv
// Serial USB CRC16 engine: accumulates data_in LSB-first while cwe_z=1, shifts the
// inverted CRC out on data_out while cwe_z=0, and flags a bad residue on chck_enbl.
module crc_16
  import crc16_pkt_ctrl_pkg::*;
(
  input  logic clk_c,
  input  logic reset,
  input  logic cwe_z,
  input  logic halt_tx,
  input  logic chck_enbl,
  input  logic data_in,
  output logic data_out,
  output logic err
);

  logic [15:0] crc_q, crc_d;
  logic        err_q, err_d;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    crc_d = crc_q;
    err_d = err_q;
    if (!halt_tx) begin
      crc_d = cwe_z ? crc16_step(crc_q, data_in) : {crc_q[14:0], 1'b0};
    end
    if (chck_enbl) begin
      err_d = (crc_q != CRC16_RESIDUE);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_c) begin
    if (reset) begin
      crc_q <= CRC16_INIT;
      err_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      err_q <= err_d;
    end
  end

  assign data_out = cwe_z ? data_in : ~crc_q[15];
  assign err      = err_q;

endmodule

// File: rtl/crc16_pkt_ctrl.sv
// Packet controller for the serial CRC16 engine: feeds payload bytes LSB-first,
// then either shifts out the CRC (transmit) or checks the residue (receive).
module crc16_pkt_ctrl
  import crc16_pkt_ctrl_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk_c,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] byte_cnt,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             stuff_halt,
  output logic             crc_rst,
  output logic             crc_cwe,
  output logic             crc_halt,
  output logic             crc_chk,
  output logic             crc_din,
  input  logic             crc_err_in,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One extra bit so MAX_BYTES plus the two received CRC bytes always fits.
  localparam int               REM_W   = CNT_W + 1;
  localparam logic [REM_W-1:0] MAX_REM = REM_W'(MAX_BYTES);

  pkt_state_e       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;

  logic [REM_W-1:0] cnt_ext;
  logic [REM_W-1:0] cnt_clamped;
  logic             bit_take;
  pkt_state_e       after_payload;

  assign cnt_ext       = {1'b0, byte_cnt};
  assign cnt_clamped   = (cnt_ext > MAX_REM) ? MAX_REM : cnt_ext;
  assign bit_take      = ((state_q == DATA) || (state_q == CRC)) && !stuff_halt;
  assign after_payload = mode_q ? CHECK : CRC;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    mode_d    = mode_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = INIT;
          mode_d    = mode;
          rem_d     = mode ? (cnt_clamped + REM_W'(2)) : cnt_clamped;
          bit_cnt_d = 4'd0;
          err_d     = 1'b0;
        end
      end
      INIT: state_d = (rem_q != '0) ? LOAD : after_payload;
      LOAD: begin
        if (byte_valid) begin
          shift_d   = byte_in;
          rem_d     = rem_q - 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (!stuff_halt) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            state_d   = (rem_q != '0) ? LOAD : after_payload;
          end
        end
      end
      CRC: begin
        if (!stuff_halt) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = 4'd0;
            state_d   = DONE;
          end
        end
      end
      CHECK: state_d = WAIT;
      WAIT: begin
        err_d   = crc_err_in;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the registered state; reset overrides them so the engine
  // is held in reset for as long as this block is.
  always_comb begin
    byte_ready = 1'b0;
    bit_strobe = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    crc_rst    = 1'b1;
    crc_halt   = 1'b1;
    crc_cwe    = 1'b1;
    crc_chk    = 1'b0;
    crc_din    = 1'b0;
    if (!reset) begin
      crc_rst    = (state_q == INIT);
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      err        = err_q;
      byte_ready = (state_q == LOAD);
      bit_strobe = bit_take;
      crc_chk    = (state_q == CHECK);
      if (state_q == DATA) begin
        crc_halt = stuff_halt;
        crc_din  = shift_q[0];
      end else if (state_q == CRC) begin
        crc_halt = stuff_halt;
        crc_cwe  = 1'b0;
      end
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk_c) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_crc16_pkt_ctrl.sv
// Closed-loop bench: crc16_pkt_ctrl driving the crc_16 engine, with an independent
// reflected-form USB CRC16 model feeding a scoreboard of expected engine output bits.
module tb_crc16_pkt_ctrl;

  localparam int CNT_W     = 11;
  localparam int MAX_BYTES = 1024;

  typedef logic [7:0] byte_q_t[$];

  logic             clk_c = 1'b0;
  logic             reset;
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             stuff_halt;
  logic             crc_rst, crc_cwe, crc_halt, crc_chk, crc_din;
  logic             crc_err_in;
  logic             bit_strobe, busy, done, err;
  logic             eng_dout;

  always #5 clk_c = ~clk_c;

  crc16_pkt_ctrl #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk_c      (clk_c),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .byte_cnt   (byte_cnt),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .stuff_halt (stuff_halt),
    .crc_rst    (crc_rst),
    .crc_cwe    (crc_cwe),
    .crc_halt   (crc_halt),
    .crc_chk    (crc_chk),
    .crc_din    (crc_din),
    .crc_err_in (crc_err_in),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  crc_16 eng (
    .clk_c     (clk_c),
    .reset     (crc_rst),
    .cwe_z     (crc_cwe),
    .halt_tx   (crc_halt),
    .chck_enbl (crc_chk),
    .data_in   (crc_din),
    .data_out  (eng_dout),
    .err       (crc_err_in)
  );

  int          n_cmp;
  int          n_bad;
  logic        exp_bits[$];
  logic [15:0] cap_crc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reflected CRC-16/USB: init FFFF, poly A001, result inverted; bit i is sent i-th.
  function automatic logic [15:0] usb_crc(input byte_q_t b, input int n);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      r = r ^ {8'h00, b[i]};
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return ~r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"},       busy,       0);
    check({tag, ":done"},       done,       0);
    check({tag, ":err"},        err,        0);
    check({tag, ":byte_ready"}, byte_ready, 0);
    check({tag, ":bit_strobe"}, bit_strobe, 0);
    check({tag, ":crc_rst"},    crc_rst,    1);
    check({tag, ":crc_halt"},   crc_halt,   1);
    check({tag, ":crc_cwe"},    crc_cwe,    1);
    check({tag, ":crc_chk"},    crc_chk,    0);
    check({tag, ":crc_din"},    crc_din,    0);
  endtask

  // One packet; exp_cyc=0 skips the latency check (used with stalls and gaps).
  task automatic run_pkt(input string name, input logic m, input int cnt, input byte_q_t pay,
                         input bit stall, input int exp_cyc);
    int          n_eff, nb, idx, budget;
    logic [15:0] crc;
    logic        exp_err;
    bit          got_done;
    n_eff   = (cnt > MAX_BYTES) ? MAX_BYTES : cnt;
    nb      = m ? n_eff + 2 : n_eff;
    crc     = usb_crc(pay, n_eff);
    exp_err = m ? (crc != {pay[n_eff+1], pay[n_eff]}) : 1'b0;
    exp_bits.delete();
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < 8; j++) exp_bits.push_back(pay[i][j]);
    if (!m)
      for (int j = 0; j < 16; j++) exp_bits.push_back(crc[j]);
    budget = (exp_cyc > 0) ? exp_cyc + 20 : 30 * (nb + 2) + 100;

    @(negedge clk_c);
    start = 1'b1; mode = m; byte_cnt = CNT_W'(cnt); byte_valid = 1'b0; stuff_halt = 1'b0;
    @(negedge clk_c);
    idx = 0; got_done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (k > 0) @(negedge clk_c);
      // A second start while busy, with different parameters, must be ignored.
      start      = (k == 3);
      mode       = (k == 3) ? ~m : m;
      byte_cnt   = (k == 3) ? CNT_W'(7) : CNT_W'(cnt);
      stuff_halt = stall && (k % 7 == 6);
      byte_valid = !(stall && (k % 3 == 0));
      byte_in    = (idx < pay.size()) ? pay[idx] : 8'h00;
      #1;
      if (k == 0) begin
        check({name, ":busy_init"}, busy,    1);
        check({name, ":crc_rst_init"}, crc_rst, 1);
        check({name, ":err_cleared"}, err,   0);
      end
      if (k == 1) check({name, ":crc_rst_once"}, crc_rst, 0);
      if (stuff_halt) begin
        check({name, ":strobe_in_stall"}, bit_strobe, 0);
        check({name, ":halt_in_stall"},   crc_halt,   1);
      end
      if (bit_strobe) begin
        check({name, ":bit_expected"}, 32'(exp_bits.size() != 0), 1);
        if (exp_bits.size() != 0) check({name, ":bit"}, eng_dout, exp_bits.pop_front());
        cap_crc = {eng_dout, cap_crc[15:1]};
      end
      if (byte_valid && byte_ready) idx++;
      if (done) begin
        got_done = 1'b1;
        if (exp_cyc > 0) check({name, ":done_cycle"}, k, exp_cyc);
        check({name, ":err"}, err, exp_err);
        break;
      end
    end
    check({name, ":done_seen"}, got_done, 1);
    check({name, ":bits_left"}, exp_bits.size(), 0);
    @(negedge clk_c);
    start = 1'b0; stuff_halt = 1'b0; byte_valid = 1'b0;
    #1;
    check({name, ":done_pulse"}, done, 0);
    check({name, ":idle_busy"},  busy, 0);
    check({name, ":err_held"},   err,  exp_err);
  endtask

  // Start a 4-byte transmit, then reset while the second byte is being shifted.
  task automatic abort_pkt();
    @(negedge clk_c);
    start = 1'b1; mode = 1'b0; byte_cnt = CNT_W'(4);
    byte_valid = 1'b1; byte_in = 8'hA5; stuff_halt = 1'b0;
    @(negedge clk_c);
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      #1 check("abort:no_done", done, 0);
      @(negedge clk_c);
    end
    #1 check("abort:mid_data", bit_strobe, 1);
    reset = 1'b1;
    #1 check_reset_outputs("abort_async_view");
    @(negedge clk_c);
    #1 check_reset_outputs("abort_after_edge");
    @(negedge clk_c);
    reset = 1'b0; byte_valid = 1'b0;
  endtask

  initial begin
    byte_q_t     p;
    logic [15:0] cap_a;
    logic [15:0] c;
    reset = 1'b1; start = 1'b0; mode = 1'b0; byte_cnt = '0;
    byte_in = 8'h00; byte_valid = 1'b0; stuff_halt = 1'b0;
    n_cmp = 0; n_bad = 0; cap_crc = 16'h0000;

    repeat (3) @(negedge clk_c);
    #1 check_reset_outputs("por");
    @(negedge clk_c);
    reset = 1'b0;
    #1;
    check("por:idle_busy",    busy,    0);
    check("por:idle_crc_rst", crc_rst, 0);

    p.delete();
    run_pkt("tx_empty", 1'b0, 0, p, 1'b0, 17);

    p.delete();
    for (int i = 0; i < 4; i++) p.push_back(8'(i));
    run_pkt("tx4", 1'b0, 4, p, 1'b0, 53);
    cap_a = cap_crc;

    p.push_back(cap_a[7:0]);
    p.push_back(cap_a[15:8]);
    run_pkt("rx4", 1'b1, 4, p, 1'b0, 57);

    p[2] = p[2] ^ 8'h01;
    run_pkt("rx4_flip", 1'b1, 4, p, 1'b0, 57);

    p.delete();
    for (int i = 0; i < 4; i++) p.push_back(8'(i));
    run_pkt("tx4_stall", 1'b0, 4, p, 1'b1, 0);

    abort_pkt();
    p.delete();
    run_pkt("tx_after_reset", 1'b0, 0, p, 1'b0, 17);

    p.delete();
    for (int i = 0; i < 3; i++) p.push_back(8'($urandom_range(0, 255)));
    c = usb_crc(p, 3);
    p.push_back(c[7:0]);
    p.push_back(c[15:8]);
    run_pkt("rx3_rand", 1'b1, 3, p, 1'b0, 48);

    p.delete();
    for (int i = 0; i < 5; i++) p.push_back(8'($urandom_range(0, 255)));
    c = usb_crc(p, 5);
    p.push_back(c[7:0]);
    p.push_back(c[15:8]);
    run_pkt("rx5_stall", 1'b1, 5, p, 1'b1, 0);

    p.delete();
    for (int i = 0; i < MAX_BYTES; i++) p.push_back(8'($urandom_range(0, 255)));
    run_pkt("tx_clamp", 1'b0, 1500, p, 1'b0, 17 + 9 * MAX_BYTES);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc16_pkt_ctrl.md
CRC16_PKT_CTRL -- requirements
Module: crc16_pkt_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 1024, meaning maximum payload bytes per packet.
REQ-002 SHALL have parameter CNT_W, default 11, meaning width of byte counters.
REQ-003 SHALL have port clk_c  in  1  clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle packet start; ignored unless busy=0.
REQ-006 SHALL have port mode  in  1  0=transmit (generate CRC), 1=receive (check CRC); sampled with start.
REQ-007 SHALL have port byte_cnt  in  CNT_W  payload bytes excluding CRC, 0..MAX_BYTES; sampled with start.
REQ-008 SHALL have ports byte_in  in  8  payload byte; byte_valid  in  1; byte_ready  out  1  (byte accepted when valid&ready).
REQ-009 SHALL have port stuff_halt  in  1  bit-stuffer stall; no bit consumed in a cycle where it is high.
REQ-010 SHALL have ports crc_rst, crc_cwe, crc_halt, crc_chk, crc_din  out  1 each  driving the serial CRC16 engine's reset, cwe_z, halt_tx, chck_enbl and data_in.
REQ-011 SHALL have port crc_err_in  in  1  engine error flag.
REQ-012 SHALL have ports bit_strobe  out  1 (engine output bit valid this cycle), busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (receive CRC mismatch, valid while done=1).

Function
REQ-013 SHALL implement states IDLE, INIT, LOAD, DATA, CRC, CHECK, WAIT, DONE.
REQ-014 IDLE->INIT when start=1; busy=1 in every state except IDLE.
REQ-015 INIT: crc_rst=1 for exactly one cycle; next LOAD if remaining bytes>0, else CRC (mode=0) or CHECK (mode=1).
REQ-016 Remaining bytes SHALL be loaded as byte_cnt (mode=0) or byte_cnt+2 (mode=1, received CRC bytes fed through engine).
REQ-017 LOAD: byte_ready=1; on valid&ready capture byte_in into shift register, decrement remaining, go DATA; stay in LOAD otherwise.
REQ-018 DATA: crc_din=shift_reg[0] (LSB first); crc_cwe=1; crc_halt=stuff_halt; shift when stuff_halt=0; after 8th consumed bit go LOAD if remaining>0, else CRC (mode=0) or CHECK (mode=1).
REQ-019 CRC (mode=0 only): crc_cwe=0, crc_halt=stuff_halt; 16 consumed bits then DONE.
REQ-020 bit_strobe SHALL equal (state==DATA or state==CRC) & ~stuff_halt.
REQ-021 CHECK: crc_chk=1 for one cycle, crc_halt=1, then WAIT; WAIT samples crc_err_in into err, then DONE.
REQ-022 DONE: done=1 one cycle, then IDLE; err held until next start, cleared to 0 on start.
REQ-023 Outside DATA/CRC: crc_halt=1, crc_cwe=1, crc_din=0; crc_chk=0 outside CHECK; crc_rst=0 outside INIT.
REQ-024 With byte_valid always 1 and stuff_halt always 0: done SHALL assert 17+9N cycles (mode=0) or 21+9N cycles (mode=1) after the edge sampling start, N=byte_cnt.
REQ-025 byte_cnt>MAX_BYTES SHALL be clamped to MAX_BYTES.
REQ-026 start while busy=1 SHALL have no effect.

Reset
REQ-027 reset SHALL force IDLE, clear counters and shift register, and drive busy=0, done=0, err=0, byte_ready=0, bit_strobe=0, crc_rst=1, crc_halt=1, crc_cwe=1, crc_chk=0, crc_din=0.
REQ-028 reset mid-packet SHALL abort without a done pulse; first start afterwards SHALL behave as from power-up.

Structure
REQ-029 State encoding and MAX_BYTES/CNT_W defaults SHALL live in the shared USB package.
REQ-030 No sub-module; bench SHALL instantiate it with crc_16 to form a closed loop.

Verification
REQ-031 tx, byte_cnt=0 -> 16 bit_strobes of engine output all 0 (CRC of empty packet = 0x0000 inverted residue), done at cycle 17.
REQ-032 tx bytes 0x00,0x01,0x02,0x03 captured, replayed as rx byte_cnt=4 with captured CRC -> err=0, done at cycle 57.
REQ-033 Same rx with bit 0 of byte 2 flipped -> err=1.
REQ-034 tx 4 bytes, stuff_halt high every 7th cycle, byte_valid gaps -> CRC bits identical to REQ-032, engine state frozen during stalls.
REQ-035 reset asserted mid-DATA, then tx byte_cnt=0 -> no done before reset, then REQ-031 response; start during busy ignored.
